reg_write_arbiter: RTL and testbench

Shares the instruction processor's single register-write port (one-hot `regChoose`, 16-bit `regData`) among four independent writers. Writers are, by convention, the ALU result, the memory load unit, the branch unit and the stack unit. The block runs a request/grant handshake and commits at most one register write per clock cycle. It can optionally lock out instruction-pointer writes while a fetch must not be disturbed. It sits between the execution units and `InstructionProcessor`, and its `regChoose`/`regData` outputs drive that block directly.

---
 rtl/reg_write_arbiter.sv | 124 ++++++++++++
 tb/tb_reg_write_arbiter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: arbitrates four register writers onto the single
// one-hot register-write port of InstructionProcessor. One write per cycle,
// registered grant/write outputs. A requester granted in the current cycle is
// masked from that cycle's decision. Optional ip-write lockout via ipLock.
// Policy: fixed priority (0 highest) by default; round-robin when the macro
// REG_ARB_ROUND_ROBIN_EN is defined.
module reg_write_arbiter #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned REGS_CODING = 8,
    parameter int unsigned REQS        = 4
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic [REQS-1:0]                        req,
    input  logic [$clog2(REGS_CODING)*REQS-1:0]    reqReg,
    input  logic [WIDTH*REQS-1:0]                  reqData,
    input  logic                                   ipLock,
    output logic [REQS-1:0]                        grant,
    output logic [REGS_CODING-1:0]                 regChoose,
    output logic [WIDTH-1:0]                       regData,
    output logic                                   busy
);

    localparam int unsigned IDXW = $clog2(REGS_CODING);
    localparam int unsigned PTRW = $clog2(REQS);
    localparam logic [IDXW-1:0] IP_INDEX = IDXW'(REGS_CODING - 1);

    logic [REQS-1:0]        eligible;
    logic                   found;
    logic [PTRW-1:0]        win_idx;
    logic [REQS-1:0]        win_oh;
    logic [IDXW-1:0]        win_reg;
    logic [WIDTH-1:0]       win_data;
    logic [REGS_CODING-1:0] choose_next;
    logic                   busy_next;

`ifdef REG_ARB_ROUND_ROBIN_EN
    logic [PTRW-1:0]        ptr;
    logic [PTRW-1:0]        cand;
`endif

    // Eligibility: pending, not granted this cycle, and not an ip write while locked.
    always_comb begin
        eligible = '0;
        for (int unsigned i = 0; i < REQS; i++) begin
            eligible[i] = req[i] && !grant[i] &&
                          !(ipLock && (reqReg[i*IDXW +: IDXW] == IP_INDEX));
        end
    end

    // Winner selection and write-data mux.
    always_comb begin
        found    = 1'b0;
        win_idx  = '0;
        win_oh   = '0;
        win_reg  = '0;
        win_data = '0;
`ifdef REG_ARB_ROUND_ROBIN_EN
        cand     = '0;
        // Search starts after the last winner; the add wraps modulo REQS.
        for (int unsigned k = 1; k <= REQS; k++) begin
            cand = ptr + PTRW'(k);
            if (!found && eligible[cand]) begin
                found   = 1'b1;
                win_idx = cand;
            end
        end
`else
        for (int unsigned i = 0; i < REQS; i++) begin
            if (!found && eligible[i]) begin
                found   = 1'b1;
                win_idx = PTRW'(i);
            end
        end
`endif
        for (int unsigned i = 0; i < REQS; i++) begin
            if (win_idx == PTRW'(i)) begin
                win_reg  = reqReg[i*IDXW +: IDXW];
                win_data = reqData[i*WIDTH +: WIDTH];
            end
        end
        if (found) begin
            win_oh[win_idx] = 1'b1;
        end
    end

    // Next-cycle write strobe and contention flag.
    always_comb begin
        choose_next = '0;
        if (found) begin
            choose_next = REGS_CODING'(1) << win_reg;
        end
        busy_next = |(req & ~grant & ~win_oh);
    end

    // Registered grant/write outputs; regData holds when nothing wins.
    always_ff @(posedge clock) begin
        if (reset) begin
            grant     <= '0;
            regChoose <= '0;
            regData   <= '0;
            busy      <= 1'b0;
        end else begin
            grant     <= win_oh;
            regChoose <= choose_next;
            busy      <= busy_next;
            if (found) begin
                regData <= win_data;
            end
        end
    end

`ifdef REG_ARB_ROUND_ROBIN_EN
    // Round-robin pointer: last granted index, moves only on a grant.
    always_ff @(posedge clock) begin
        if (reset) begin
            ptr <= PTRW'(REQS - 1);
        end else if (found) begin
            ptr <= win_idx;
        end
    end
`endif

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter: directed vector table, a reset-mid-grant
// sequence, then randomized traffic against a behavioural reference model.
module tb_reg_write_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [11:0] reqReg;
    logic [63:0] reqData;
    logic        ipLock;
    logic [3:0]  grant;
    logic [7:0]  regChoose;
    logic [15:0] regData;
    logic        busy;

    int unsigned checks = 0;
    int unsigned passes = 0;

    reg_write_arbiter #(.WIDTH(16), .REGS_CODING(8), .REQS(4)) dut (
        .clock(clock), .reset(reset), .req(req), .reqReg(reqReg),
        .reqData(reqData), .ipLock(ipLock), .grant(grant),
        .regChoose(regChoose), .regData(regData), .busy(busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit          rst;
        logic [3:0]  rq;
        logic [11:0] regs;
        logic [63:0] data;
        bit          lk;
        logic [3:0]  eg;
        logic [7:0]  ec;
        logic [15:0] ed;
        logic        eb;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit rst, logic [3:0] rq,
                                int r0, int r1, int r2, int r3,
                                int d0, int d1, int d2, int d3, bit lk,
                                logic [3:0] eg, logic [7:0] ec, int ed, logic eb);
        vec_t v;
        v.rst  = rst;
        v.rq   = rq;
        v.regs = {3'(r3), 3'(r2), 3'(r1), 3'(r0)};
        v.data = {16'(d3), 16'(d2), 16'(d1), 16'(d0)};
        v.lk   = lk;
        v.eg   = eg;
        v.ec   = ec;
        v.ed   = 16'(ed);
        v.eb   = eb;
        return v;
    endfunction

    // Reference model: state after the most recent edge.
    logic [3:0]  m_grant = '0;
    logic [7:0]  m_choose = '0;
    logic [15:0] m_data = '0;
    logic        m_busy = 1'b0;
    int          m_last = 3;

    task automatic model_update();
        int winner = -1;
        bit loser = 1'b0;
        bit ok[4];
        if (reset) begin
            m_grant = '0; m_choose = '0; m_data = '0; m_busy = 1'b0; m_last = 3;
            return;
        end
        for (int i = 0; i < 4; i++)
            ok[i] = req[i] && !m_grant[i] && !(ipLock && reqReg[3*i +: 3] == 3'd7);
`ifdef REG_ARB_ROUND_ROBIN_EN
        for (int k = 1; k <= 4; k++) begin
            int j = (m_last + k) % 4;
            if (winner < 0 && ok[j]) winner = j;
        end
`else
        for (int i = 0; i < 4; i++)
            if (winner < 0 && ok[i]) winner = i;
`endif
        for (int i = 0; i < 4; i++)
            if (req[i] && !m_grant[i] && i != winner) loser = 1'b1;
        if (winner >= 0) begin
            m_grant  = 4'(1 << winner);
            m_choose = 8'(1 << reqReg[3*winner +: 3]);
            m_data   = reqData[16*winner +: 16];
            m_last   = winner;
        end else begin
            m_grant  = '0;
            m_choose = '0;
        end
        m_busy = loser;
    endtask

    task automatic tick();
        model_update();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic check_all(input string tag, input logic [3:0] eg, input logic [7:0] ec,
                             input logic [15:0] ed, input logic eb);
        check($sformatf("%s grant", tag), 32'(grant), 32'(eg));
        check($sformatf("%s regChoose", tag), 32'(regChoose), 32'(ec));
        check($sformatf("%s regData", tag), 32'(regData), 32'(ed));
        check($sformatf("%s busy", tag), 32'(busy), 32'(eb));
    endtask

    initial begin
        reset = 1'b1; req = '0; reqReg = '0; reqData = '0; ipLock = 1'b0;

        // Reset held with all requesting.
        for (int n = 0; n < 4; n++)
            vecs.push_back(mk(1, 4'b1111, 2,2,2,2, 1,2,3,4, 0, 4'b0000, 8'h00, 0, 0));
        // Single write, then idle hold.
        vecs.push_back(mk(0, 4'b0001, 2,0,0,0, 10,0,0,0, 0, 4'b0001, 8'h04, 10, 0));
        vecs.push_back(mk(0, 4'b0000, 2,0,0,0, 10,0,0,0, 0, 4'b0000, 8'h00, 10, 0));
        // Contention between 1 (reg 6) and 3 (reg 2).
        vecs.push_back(mk(0, 4'b1010, 0,6,0,2, 0,65535,0,5, 0, 4'b0010, 8'h40, 65535, 1));
        vecs.push_back(mk(0, 4'b1010, 0,6,0,2, 0,65535,0,5, 0, 4'b1000, 8'h04, 5, 0));
        vecs.push_back(mk(0, 4'b1010, 0,6,0,2, 0,65535,0,5, 0, 4'b0010, 8'h40, 65535, 0));
        vecs.push_back(mk(0, 4'b0000, 0,6,0,2, 0,65535,0,5, 0, 4'b0000, 8'h00, 65535, 0));
        // Post-grant mask: single held requester alternates.
        vecs.push_back(mk(0, 4'b0001, 3,0,0,0, 'hAA,0,0,0, 0, 4'b0001, 8'h08, 'hAA, 0));
        vecs.push_back(mk(0, 4'b0001, 3,0,0,0, 'hAA,0,0,0, 0, 4'b0000, 8'h00, 'hAA, 0));
        vecs.push_back(mk(0, 4'b0001, 3,0,0,0, 'hAA,0,0,0, 0, 4'b0001, 8'h08, 'hAA, 0));
        vecs.push_back(mk(0, 4'b0001, 3,0,0,0, 'hAA,0,0,0, 0, 4'b0000, 8'h00, 'hAA, 0));
        vecs.push_back(mk(0, 4'b0000, 3,0,0,0, 'hAA,0,0,0, 0, 4'b0000, 8'h00, 'hAA, 0));
        // ipLock blocks the ip write, then release.
        for (int n = 0; n < 4; n++)
            vecs.push_back(mk(0, 4'b0100, 0,0,7,0, 0,0,0,0, 1, 4'b0000, 8'h00, 'hAA, 1));
        vecs.push_back(mk(0, 4'b0100, 0,0,7,0, 0,0,0,0, 0, 4'b0100, 8'h80, 0, 0));
        vecs.push_back(mk(0, 4'b0000, 0,0,7,0, 0,0,0,0, 0, 4'b0000, 8'h00, 0, 0));
        // Same target register: serialized, last write lands later.
        vecs.push_back(mk(0, 4'b0101, 4,0,4,0, 1,0,2,0, 0, 4'b0001, 8'h10, 1, 1));
        vecs.push_back(mk(0, 4'b0101, 4,0,4,0, 1,0,2,0, 0, 4'b0100, 8'h10, 2, 0));
        vecs.push_back(mk(0, 4'b0000, 4,0,4,0, 1,0,2,0, 0, 4'b0000, 8'h00, 2, 0));

        foreach (vecs[n]) begin
            reset = vecs[n].rst; req = vecs[n].rq; reqReg = vecs[n].regs;
            reqData = vecs[n].data; ipLock = vecs[n].lk;
            tick();
            check_all($sformatf("vec%0d", n), vecs[n].eg, vecs[n].ec, vecs[n].ed, vecs[n].eb);
        end

        // Reset while a grant is visible; pending req1 wins after release.
        reset = 1'b0; req = 4'b0011; reqReg = {3'd0, 3'd0, 3'd5, 3'd1};
        reqData = {16'h0, 16'h0, 16'h0022, 16'h0011};
        tick();
        check_all("rst_mid pre", 4'b0001, 8'h02, 16'h0011, 1'b1);
        reset = 1'b1; req = 4'b0010;
        tick();
        check_all("rst_mid reset", 4'b0000, 8'h00, 16'h0000, 1'b0);
        reset = 1'b0;
        tick();
        check_all("rst_mid after", 4'b0010, 8'h20, 16'h0022, 1'b0);
        req = 4'b0000;
        tick();
        check_all("rst_mid idle", 4'b0000, 8'h00, 16'h0022, 1'b0);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 600; n++) begin
            reset   = ($urandom_range(0, 49) == 0);
            req     = 4'($urandom);
            reqReg  = 12'($urandom);
            reqData = {$urandom, $urandom};
            ipLock  = ($urandom_range(0, 3) == 0);
            tick();
            check_all($sformatf("rand%0d", n), m_grant, m_choose, m_data, m_busy);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
